// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the architectural PC, issues instruction fetches and
// computes the next PC from decoder jump/call/return requests.
//
// Configuration macro: PC_SEQ_RAS_EN
//   defined   -> return-address stack, stack_ovf/stack_unf flags, HALT state.
//   undefined -> no stack; call_en acts as jump_en, ret_en is ignored,
//                halted/stack_ovf/stack_unf tie to 0.
//
// Ports:
//   clk, reset_n          clock (rising edge), async active-low reset
//   run                   leave IDLE / continue after EXEC while high
//   fetch_valid/addr/ready  fetch request channel to instruction memory
//   jump_en/call_en/ret_en/jump_addr  decoder requests, sampled in EXEC only
//   pc                    current PC
//   halted                sequencer stopped in HALT until reset
//   stack_ovf/stack_unf   sticky stack error flags
//   dbg_state_o           current FSM state, for observation only
//
// Fetch handshake: fetch_valid is high exactly while in FETCH and fetch_addr
// is pc_q, which cannot change in FETCH, so the request stays stable until
// the cycle fetch_valid && fetch_ready, when it is consumed. fetch_ready is
// ignored in every other state.
module pc_sequencer #(
  parameter int              PC_W        = 16,
  parameter int              JADDR_W     = 12,
  parameter int              STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               run,
  output logic               fetch_valid,
  output logic [PC_W-1:0]    fetch_addr,
  input  logic               fetch_ready,
  input  logic               jump_en,
  input  logic               call_en,
  input  logic               ret_en,
  input  logic [JADDR_W-1:0] jump_addr,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output logic               stack_ovf,
  output logic               stack_unf,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] jump_tgt;

  // Increment wraps naturally at 2^PC_W; the target is zero-extended.
  assign pc_inc   = pc_q + PC_W'(1);
  assign jump_tgt = PC_W'(jump_addr);

`ifdef PC_SEQ_RAS_EN
  localparam int              PTR_W    = $clog2(STACK_DEPTH);
  localparam int              CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STACK_DEPTH);

  logic [PC_W-1:0]  ras_q [STACK_DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push, pop;
  logic [PTR_W-1:0] top_idx;
  logic [PC_W-1:0]  ras_top;

  assign top_idx = PTR_W'(cnt_q - CNT_W'(1));
  assign ras_top = ras_q[top_idx];
  assign cnt_d   = push ? (cnt_q + CNT_W'(1)) :
                   pop  ? (cnt_q - CNT_W'(1)) : cnt_q;
`else
  logic unused_ok;
  assign unused_ok = ret_en ^ (STACK_DEPTH > 1);
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef PC_SEQ_RAS_EN
    push    = 1'b0;
    pop     = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (fetch_ready) state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = run ? S_FETCH : S_IDLE;
`ifdef PC_SEQ_RAS_EN
        // Priority ret > call > jump > increment; an error leaves pc as is.
        if (ret_en) begin
          if (cnt_q == '0) begin
            unf_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            pop  = 1'b1;
            pc_d = ras_top;
          end
        end else if (call_en) begin
          if (cnt_q == CNT_FULL) begin
            ovf_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            push = 1'b1;
            pc_d = jump_tgt;
          end
        end else if (jump_en) begin
          pc_d = jump_tgt;
        end else begin
          pc_d = pc_inc;
        end
`else
        if (jump_en || call_en) pc_d = jump_tgt;
        else                    pc_d = pc_inc;
`endif
      end
      default: begin
        // S_HALT: terminal until reset
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef PC_SEQ_RAS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack storage needs no reset: cnt_q alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) ras_q[cnt_q[PTR_W-1:0]] <= pc_inc;
  end

  assign halted    = (state_q == S_HALT);
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;
`else
  assign halted    = 1'b0;
  assign stack_ovf = 1'b0;
  assign stack_unf = 1'b0;
`endif

  assign fetch_valid = (state_q == S_FETCH);
  assign fetch_addr  = pc_q;
  assign pc          = pc_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int STACK_DEPTH = 4;
  localparam int PH_IDLE  = 0;
  localparam int PH_FETCH = 1;
  localparam int PH_EXEC  = 2;
  localparam int PH_HALT  = 3;

  // main instance signals
  logic        clk, reset_n, run, fetch_ready, jump_en, call_en, ret_en;
  logic [11:0] jump_addr;
  logic        fetch_valid;
  logic [15:0] fetch_addr, pc;
  logic        halted, stack_ovf, stack_unf;
  logic [1:0]  dbg_state_unused;

  // wrap instance signals (reset PC near the top of the address space)
  logic        w_run, w_ready, w_jump, w_call, w_ret;
  logic [11:0] w_jaddr;
  logic        w_fv;
  logic [15:0] w_fa, w_pc;
  logic        w_halted, w_ovf, w_unf;
  logic [1:0]  w_dbg_unused;

  int n_total = 0;
  int n_bad   = 0;

  pc_sequencer #(.PC_W(16), .JADDR_W(12), .STACK_DEPTH(STACK_DEPTH), .RESET_PC(16'h0000)) u_dut (
    .clk(clk), .reset_n(reset_n), .run(run),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .jump_en(jump_en), .call_en(call_en), .ret_en(ret_en), .jump_addr(jump_addr),
    .pc(pc), .halted(halted), .stack_ovf(stack_ovf), .stack_unf(stack_unf),
    .dbg_state_o(dbg_state_unused)
  );

  pc_sequencer #(.PC_W(16), .JADDR_W(12), .STACK_DEPTH(STACK_DEPTH), .RESET_PC(16'hFFFE)) u_wrap (
    .clk(clk), .reset_n(reset_n), .run(w_run),
    .fetch_valid(w_fv), .fetch_addr(w_fa), .fetch_ready(w_ready),
    .jump_en(w_jump), .call_en(w_call), .ret_en(w_ret), .jump_addr(w_jaddr),
    .pc(w_pc), .halted(w_halted), .stack_ovf(w_ovf), .stack_unf(w_unf),
    .dbg_state_o(w_dbg_unused)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Instruction-level view: which phase the current instruction is in, the
  // architectural pc, and the return stack as a plain queue.
  int          m_ph  = PH_IDLE;
  int          m_pc  = 0;
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;
  logic [15:0] ras_q[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ph  = PH_IDLE;
      m_pc  = 0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      ras_q.delete();
    end else begin
      case (m_ph)
        PH_IDLE:  if (run) m_ph = PH_FETCH;
        PH_FETCH: if (fetch_ready) m_ph = PH_EXEC;
        PH_EXEC: begin
          m_ph = run ? PH_FETCH : PH_IDLE;
`ifdef PC_SEQ_RAS_EN
          if (ret_en) begin
            if (ras_q.size() == 0) begin
              m_unf = 1'b1;
              m_ph  = PH_HALT;
            end else begin
              m_pc = int'(ras_q.pop_back());
            end
          end else if (call_en) begin
            if (ras_q.size() == STACK_DEPTH) begin
              m_ovf = 1'b1;
              m_ph  = PH_HALT;
            end else begin
              ras_q.push_back(16'((m_pc + 1) % 65536));
              m_pc = int'(jump_addr);
            end
          end else if (jump_en) begin
            m_pc = int'(jump_addr);
          end else begin
            m_pc = (m_pc + 1) % 65536;
          end
`else
          if (jump_en || call_en) m_pc = int'(jump_addr);
          else                    m_pc = (m_pc + 1) % 65536;
`endif
        end
        default: ;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h at t=%0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    check("fetch_valid", 32'(fetch_valid), 32'(m_ph == PH_FETCH));
    if (fetch_valid) check("fetch_addr", 32'(fetch_addr), 32'(m_pc));
    check("pc", 32'(pc), 32'(m_pc));
    check("halted", 32'(halted), 32'(m_ph == PH_HALT));
    check("stack_ovf", 32'(stack_ovf), 32'(m_ovf));
    check("stack_unf", 32'(stack_unf), 32'(m_unf));
  end

  // ---------------- driver tasks ----------------
  task automatic reset_pulse();
    reset_n = 1'b0; run = 1'b0; fetch_ready = 1'b0;
    jump_en = 1'b0; call_en = 1'b0; ret_en = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // One instruction: wait for the fetch, stall `delay` cycles, accept it, then
  // let EXEC run with the given requests. Requests are held from the start so
  // that they are also present (and must be ignored) during FETCH.
  task automatic do_instr(input logic j, input logic c, input logic r, input logic [11:0] a,
                          input int delay, input logic run_after, input logic wiggle);
    int n;
    run = 1'b1; fetch_ready = 1'b0;
    jump_en = j; call_en = c; ret_en = r; jump_addr = a;
    n = 0;
    while (!fetch_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!fetch_valid) begin
      n_total++; n_bad++;
      $display("FAIL fetch_timeout: got=no fetch_valid want=fetch_valid within 20 cycles");
      return;
    end
    for (int i = 0; i < delay; i++) begin
      if (wiggle) run = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    fetch_ready = 1'b1;
    @(posedge clk); #1;
    run = run_after;
    fetch_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    jump_en = 1'b0; call_en = 1'b0; ret_en = 1'b0; fetch_ready = 1'b0;
  endtask

  task automatic plain();
    do_instr(1'b0, 1'b0, 1'b0, 12'h000, 0, 1'b1, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n = 1'b1; run = 1'b0; fetch_ready = 1'b0;
    jump_en = 1'b0; call_en = 1'b0; ret_en = 1'b0; jump_addr = '0;
    w_run = 1'b1; w_ready = 1'b1; w_jump = 1'b0; w_call = 1'b0; w_ret = 1'b0; w_jaddr = 12'h123;
    #1 reset_n = 1'b0;
    #1;
    check("rst_pc", 32'(pc), 32'h0000);
    check("rst_fetch_valid", 32'(fetch_valid), 32'h0);
    check("rst_wrap_pc", 32'(w_pc), 32'hFFFE);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;

    // wrap instance: FFFE -> FFFF -> (call at FFFF pushes 0000) -> ...
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("wrap_pc_ffff", 32'(w_pc), 32'hFFFF);
    check("wrap_fetch_addr", 32'(w_fa), 32'hFFFF);
`ifdef PC_SEQ_RAS_EN
    w_call = 1'b1;
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    w_call = 1'b0; w_ret = 1'b1;
`ifdef PC_SEQ_RAS_EN
    check("wrap_call_pc", 32'(w_pc), 32'h0123);
`else
    check("wrap_inc_pc", 32'(w_pc), 32'h0000);
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    w_ret = 1'b0; w_run = 1'b0;
`ifdef PC_SEQ_RAS_EN
    check("wrap_ret_pc", 32'(w_pc), 32'h0000);
`else
    check("wrap_ret_ignored_pc", 32'(w_pc), 32'h0001);
`endif
    check("wrap_halted", 32'(w_halted), 32'h0);
    check("wrap_flags", 32'({w_ovf, w_unf}), 32'h0);

    // sequential, backpressure, jump
    plain(); plain();
    check("seq_pc2", 32'(pc), 32'h0002);
    do_instr(1'b0, 1'b0, 1'b0, 12'h000, 5, 1'b1, 1'b0);
    check("bp_pc3", 32'(pc), 32'h0003);
    plain();
    check("seq_pc4", 32'(pc), 32'h0004);
    do_instr(1'b1, 1'b0, 1'b0, 12'hAAA, 0, 1'b1, 1'b0);
    check("jump_pc", 32'(pc), 32'h0AAA);
    check("jump_fetch_addr", 32'(fetch_addr), 32'h0AAA);

    // call / return
    do_instr(1'b1, 1'b0, 1'b0, 12'h010, 1, 1'b1, 1'b0);
    check("jump10_pc", 32'(pc), 32'h0010);
    do_instr(1'b0, 1'b1, 1'b0, 12'h100, 0, 1'b1, 1'b0);
    check("call_pc", 32'(pc), 32'h0100);
    do_instr(1'b0, 1'b0, 1'b1, 12'h300, 0, 1'b1, 1'b0);
`ifdef PC_SEQ_RAS_EN
    check("ret_pc", 32'(pc), 32'h0011);
`else
    check("ret_ignored_pc", 32'(pc), 32'h0101);
`endif
    do_instr(1'b1, 1'b1, 1'b1, 12'h222, 0, 1'b1, 1'b0);
`ifdef PC_SEQ_RAS_EN
    check("unf_flag", 32'(stack_unf), 32'h1);
    check("unf_halted", 32'(halted), 32'h1);
    check("unf_pc", 32'(pc), 32'h0011);
`else
    check("all_req_pc", 32'(pc), 32'h0222);
    check("all_req_halted", 32'(halted), 32'h0);
`endif

    // nested calls up to overflow
    reset_pulse();
    for (int i = 1; i <= 5; i++) begin
      do_instr(1'b0, 1'b1, 1'b0, 12'(i), 0, 1'b1, 1'b0);
      if (i < 5) check("nest_pc", 32'(pc), 32'(i));
    end
`ifdef PC_SEQ_RAS_EN
    check("ovf_flag", 32'(stack_ovf), 32'h1);
    check("ovf_halted", 32'(halted), 32'h1);
    check("ovf_pc", 32'(pc), 32'h0004);
    run = 1'b1; fetch_ready = 1'b1; call_en = 1'b1; ret_en = 1'b1; jump_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    check("halt_frozen_pc", 32'(pc), 32'h0004);
    check("halt_no_fetch", 32'(fetch_valid), 32'h0);
`else
    check("nest5_pc", 32'(pc), 32'h0005);
    check("nest5_ovf", 32'(stack_ovf), 32'h0);
`endif

    // async reset in the middle of a stalled fetch
    reset_pulse();
    plain(); plain();
    fetch_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("stall_fetch_valid", 32'(fetch_valid), 32'h1);
    check("stall_fetch_addr", 32'(fetch_addr), 32'h0002);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_fetch_valid", 32'(fetch_valid), 32'h0);
    check("async_rst_pc", 32'(pc), 32'h0000);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // randomized instruction stream
    for (int k = 0; k < 400; k++) begin
      logic j, c, r, ra;
      if (m_ph == PH_HALT || $urandom_range(0, 49) == 0) reset_pulse();
      r  = ($urandom_range(0, 5) == 0);
      c  = ($urandom_range(0, 3) == 0);
      j  = ($urandom_range(0, 2) == 0);
      ra = ($urandom_range(0, 3) != 0);
      do_instr(j, c, r, 12'($urandom_range(0, 4095)), $urandom_range(0, 3), ra, 1'b1);
      if (!ra) begin
        for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
          fetch_ready = 1'($urandom_range(0, 1));
          jump_en = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        jump_en = 1'b0; fetch_ready = 1'b0;
      end
    end

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
